uart_tx_frame_ctrl: RTL and testbench
=====================================

UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter: data_length, default 8, number of data bits per frame (5..8).
REQ-002 Port: i_sys_clk  input  1  system clock, 50 MHz.
REQ-003 Port: i_sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: i_baud_tick  input  1  one-cycle strobe; one pulse per bit period.
REQ-005 Port: i_data  input  data_length  byte to transmit.
REQ-006 Port: i_data_valid  input  1  i_data is presented for transmission.
REQ-007 Port: o_data_ready  output  1  controller accepts a byte this cycle.
REQ-008 Port: i_parity_en  input  1  1 = insert parity bit.
REQ-009 Port: i_parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-010 Port: i_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 Port: o_txd  output  1  serial line; idle high.
REQ-012 Port: o_busy  output  1  frame in progress.

Function
REQ-013 The block SHALL instantiate the team parity generator on the latched data and pass i_parity_type sampled at accept time.
REQ-014 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-015 o_data_ready SHALL be high only in IDLE.
REQ-016 Accept SHALL occur when i_data_valid and o_data_ready are both high; i_data, i_parity_en, i_parity_type and i_stop2 SHALL be latched on the accept edge, and later changes SHALL NOT affect the frame.
REQ-017 On accept the FSM SHALL enter START; o_txd = 0 and o_busy = 1 SHALL take effect from the next cycle.
REQ-018 Every non-IDLE state SHALL advance only on a cycle where i_baud_tick = 1, so each bit lasts from one tick to the next.
REQ-019 Bit-period alignment of the first bit is the tick source's responsibility.
REQ-020 START SHALL go to DATA on a tick.
REQ-021 DATA SHALL drive the latched bits LSB first, each for one tick interval, using a bit counter from 0 to data_length-1.
REQ-022 DATA SHALL exit after bit data_length-1: to PARITY if parity is enabled, otherwise to STOP.
REQ-023 PARITY SHALL drive the latched parity bit for one tick interval, then go to STOP.
REQ-024 STOP SHALL drive o_txd = 1 for one tick interval, or two if i_stop2 was latched as 1, then go to IDLE.
REQ-025 o_busy SHALL fall and o_data_ready SHALL rise in the cycle after the final stop tick.
REQ-026 Back-to-back: with i_data_valid held high, the next byte SHALL be accepted in the first IDLE cycle (one-cycle gap minimum).
REQ-027 An i_baud_tick in IDLE SHALL be ignored.
REQ-028 i_data_valid = 1 during a frame SHALL NOT be accepted and SHALL NOT disturb the frame.
REQ-029 o_txd SHALL be registered and glitch-free.

Reset
REQ-030 Asserting i_sys_rst_n low SHALL immediately force: FSM = IDLE, o_txd = 1, o_busy = 0, o_data_ready = 0, bit counter = 0, latches = 0.
REQ-031 o_data_ready SHALL be 1 from the first clock edge after reset release.
REQ-032 Reset mid-frame SHALL abort the frame with the line high; no partial frame SHALL resume.

Configuration
REQ-033 Macro UART_TX_BREAK_EN defined: the block SHALL add input i_break (1 bit).
REQ-034 With UART_TX_BREAK_EN, i_break = 1 SHALL force o_txd = 0 on the next cycle in any state.
REQ-035 With UART_TX_BREAK_EN, i_break SHALL block accept while high and SHALL NOT alter FSM progression; o_txd SHALL return to FSM value one cycle after release.
REQ-036 Macro UART_TX_BREAK_EN undefined: there SHALL be no i_break port and o_txd SHALL be purely FSM-driven.

Verification
REQ-037 Accept 0x55, parity off, stop1, tick every 16 clk -> o_txd = 0,1,0,1,0,1,0,1,0,1 (10 bits × 16 clk); o_busy high for 160 clk.
REQ-038 Accept 0x07, parity on, even -> parity bit 1; same with odd -> parity bit 0; frame = 11 bits.
REQ-039 Accept 0xA3, i_stop2 = 1, then toggle i_stop2/i_parity_en mid-frame -> frame unchanged, two stop bit periods, ready returns after the 12th... 11th tick interval.
REQ-040 i_data_valid held high with 0x01 then 0x80 -> second START begins exactly 1 clk after first frame ends; no lost byte.
REQ-041 Assert reset during DATA bit 3 -> o_txd = 1 same cycle; after release, ready = 1 and the next accept sends a full fresh frame.
REQ-042 (UART_TX_BREAK_EN) i_break = 1 for 40 clk in IDLE -> o_txd = 0 for 40 clk, no accept; release -> o_txd = 1 next cycle, accept resumes.

Source files
------------

// File: rtl/uart_parity_gen.sv
// Shared parity generator: one parity bit over a data word, even or odd sense.
// Latency: combinational.
// Backpressure: none.
module uart_parity_gen #(
    parameter int width = 8
) (
    input  logic [width-1:0] data,
    input  logic             odd,
    output logic             parity
);
    assign parity = (^data) ^ odd;
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start bit, data LSB first, optional parity, one or two stop bits (UART_TX_BREAK_EN adds i_break).
// Latency: o_txd drops to the start bit the cycle after accept; each bit lasts one i_baud_tick interval.
// Backpressure: o_data_ready only while idle and not breaking; inputs are latched at accept.
module uart_tx_frame_ctrl #(
    parameter int data_length = 8
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    input  logic                   i_baud_tick,
    input  logic [data_length-1:0] i_data,
    input  logic                   i_data_valid,
    output logic                   o_data_ready,
    input  logic                   i_parity_en,
    input  logic                   i_parity_type,
    input  logic                   i_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                   i_break,
`endif
    output logic                   o_txd,
    output logic                   o_busy
);
    localparam int cnt_w = $clog2(data_length);
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(data_length - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_d;
    logic [cnt_w-1:0]       bit_cnt, bit_cnt_d;
    logic                   stop_cnt, stop_cnt_d;
    logic [data_length-1:0] data_q;
    logic                   par_en_q, par_type_q, stop2_q;
    logic                   armed_q, busy_q, txd_q;
    logic                   txd_d, parity_bit, accept, brk;

`ifdef UART_TX_BREAK_EN
    assign brk = i_break;
`else
    assign brk = 1'b0;
`endif

    // armed_q keeps ready low while reset is held and for no longer than one edge after release
    assign o_data_ready = armed_q && (state == IDLE) && !brk;
    assign accept       = i_data_valid && o_data_ready;

    uart_parity_gen #(.width(data_length)) u_parity (
        .data   (data_q),
        .odd    (par_type_q),
        .parity (parity_bit)
    );

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        txd_d      = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: begin
                if (i_baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (i_baud_tick) begin
                    if (bit_cnt == last_bit) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (i_baud_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (i_baud_tick) begin
                    if (stop2_q && !stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // line value is decoded from the next state so o_txd can be a plain flop
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_q[bit_cnt_d];
            PARITY:  txd_d = parity_bit;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            armed_q  <= 1'b1;
            busy_q   <= (state_d != IDLE);
            txd_q    <= brk ? 1'b0 : txd_d;
            if (accept) begin
                data_q     <= i_data;
                par_en_q   <= i_parity_en;
                par_type_q <= i_parity_type;
                stop2_q    <= i_stop2;
            end
        end
    end

    assign o_txd  = txd_q;
    assign o_busy = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: frame-level model (bit list per accepted byte, advanced per tick)
// compared every cycle, plus literal frame pins for known bytes.
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick  = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          valid = 1'b0;
    logic          pe    = 1'b0;
    logic          pt    = 1'b0;
    logic          s2    = 1'b0;
    logic          brk   = 1'b0;
    logic          txd, busy, ready;
    int            n_pass  = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.data_length(DW)) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_baud_tick   (tick),
        .i_data        (data),
        .i_data_valid  (valid),
        .o_data_ready  (ready),
        .i_parity_en   (pe),
        .i_parity_type (pt),
        .i_stop2       (s2),
`ifdef UART_TX_BREAK_EN
        .i_break       (brk),
`endif
        .o_txd         (txd),
        .o_busy        (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Frame model: serial bit list built at accept, index advanced per tick.
    logic [11:0] m_bits  = '1;
    int          m_len   = 0;
    int          m_idx   = 0;
    bit          m_in    = 0;
    bit          m_armed = 0;
    bit          m_brk_q = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in = 0; m_armed = 0; m_brk_q = 0; m_idx = 0;
        end else begin
            if (m_in) begin
                if (tick) begin
                    m_idx++;
                    if (m_idx == m_len) m_in = 0;
                end
            end else if (m_armed && valid && !brk) begin
                m_bits = '1;
                m_bits[0] = 1'b0;
                m_len = 1;
                for (int i = 0; i < DW; i++) begin
                    m_bits[m_len] = data[i];
                    m_len++;
                end
                if (pe) begin
                    m_bits[m_len] = (^data) ^ pt;
                    m_len++;
                end
                m_len += s2 ? 2 : 1;
                m_in  = 1;
                m_idx = 0;
            end
            m_armed = 1;
            m_brk_q = brk;
        end
    end

    always @(negedge clk) begin
        logic e_txd;
        e_txd = m_brk_q ? 1'b0 : (m_in ? m_bits[m_idx] : 1'b1);
        chk("txd", int'(txd), int'(e_txd));
        chk("busy", int'(busy), int'(m_in));
        chk("ready", int'(ready), int'(m_armed && !m_in && !brk));
    end

    task automatic run_ticks(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tick = (i % per == per - 1);
            @(posedge clk); #2;
        end
        tick = 1'b0;
    endtask

    // Accept one byte, tick every 16 clk aligned to the accept edge, capture mid-bit line values.
    task automatic frame_fixed(input logic [7:0] d, input bit p_en, input bit p_ty, input bit st2,
                               input bit mid, input int exp_busy, input logic [11:0] exp_bits,
                               input string nm);
        int          busy_cnt;
        logic [11:0] cap;
        data = d; pe = p_en; pt = p_ty; s2 = st2; valid = 1'b1; tick = 1'b0;
        @(posedge clk); #2;
        valid = 1'b0;
        data  = 8'($urandom);
        busy_cnt = busy ? 1 : 0;
        cap = '1;
        for (int c = 1; c <= 200; c++) begin
            tick = (c % 16 == 0);
            if (mid && c == 40) begin
                s2 = ~s2; pe = ~pe; pt = ~pt; valid = 1'b1; data = 8'($urandom);
            end
            if (mid && c == 100) valid = 1'b0;
            @(posedge clk); #2;
            if (busy) busy_cnt++;
            if (c % 16 == 8 && c / 16 < 12) cap[c / 16] = txd;
        end
        tick = 1'b0;
        chk({nm, "_bits"}, int'(cap), int'(exp_bits));
        chk({nm, "_busy_clk"}, busy_cnt, exp_busy);
    endtask

    task automatic back_to_back();
        int gap = 0;
        int t   = 0;
        bit seen_fall = 0;
        data = 8'h01; pe = 1'b0; s2 = 1'b0; valid = 1'b1;
        @(posedge clk); #2;
        data = 8'h80;
        while (t < 400) begin
            tick = (t % 4 == 3);
            @(posedge clk); #2;
            t++;
            if (!busy) seen_fall = 1;
            if (seen_fall && !busy) gap++;
            if (seen_fall && busy) break;
        end
        valid = 1'b0;
        tick  = 1'b0;
        chk("b2b_gap_clk", gap, 1);
        chk("b2b_second_busy", int'(busy), 1);
        run_ticks(200, 4);
        chk("b2b_done_idle", int'(busy), 0);
    endtask

    task automatic reset_mid();
        data = 8'hC6; pe = 1'b1; pt = 1'b0; s2 = 1'b0; valid = 1'b1;
        @(posedge clk); #2;
        valid = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            tick = (c % 16 == 0);
            @(posedge clk); #2;
        end
        tick = 1'b0;
        chk("mid_data_bit3", int'(txd), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", int'(txd), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(ready), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("mid_rel_ready", int'(ready), 1);
        run_ticks(20, 3);
        chk("idle_tick_busy", int'(busy), 0);
        chk("idle_tick_txd", int'(txd), 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("ready_after_rst", int'(ready), 1);

        frame_fixed(8'h55, 0, 0, 0, 0, 160, 12'hEAA, "f55");
        frame_fixed(8'h07, 1, 0, 0, 0, 176, 12'hE0E, "f07_even");
        frame_fixed(8'h07, 1, 1, 0, 0, 176, 12'hC0E, "f07_odd");
        frame_fixed(8'hA3, 0, 0, 1, 1, 176, 12'hF46, "fA3_stop2");
        back_to_back();
        reset_mid();
        frame_fixed(8'h55, 0, 0, 0, 0, 160, 12'hEAA, "f55_after_rst");

`ifdef UART_TX_BREAK_EN
        begin
            int low = 0;
            int acc = 0;
            data = 8'h5A; valid = 1'b1; brk = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #2;
                if (!txd) low++;
                if (busy) acc++;
            end
            brk = 1'b0; valid = 1'b0;
            @(posedge clk); #2;
            chk("brk_low_clk", low, 40);
            chk("brk_no_accept", acc, 0);
            chk("brk_release_txd", int'(txd), 1);
            frame_fixed(8'h55, 0, 0, 0, 0, 160, 12'hEAA, "f55_after_brk");
        end
`endif

        for (int i = 0; i < 4000; i++) begin
            tick  = ($urandom_range(0, 2) == 0);
            valid = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
            pe    = 1'($urandom);
            pt    = 1'($urandom);
            s2    = 1'($urandom);
            rst_n = ($urandom_range(0, 1499) != 0);
`ifdef UART_TX_BREAK_EN
            brk   = ($urandom_range(0, 29) == 0);
`endif
            @(posedge clk); #2;
        end
        rst_n = 1'b1; brk = 1'b0; valid = 1'b0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
